// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues sequential word fetches under a credit limit,
// buffers returned words with their PCs, and flushes on PC redirect.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t        q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, discard;
  logic [31:0]   fetch_pc, resp_pc, redir_pc;
  logic          issue, resp, push, pop, drop;
  logic          unused_redir_lsb;

  assign redir_pc         = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  // Two credit limits: queue space for everything in flight, and the
  // response tracker's capacity for live plus to-be-dropped requests.
  assign mem_req = !rst
                && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W)
                && (({1'b0, outstanding} + {1'b0, discard}) < DEPTH_W);
  assign mem_addr = rst ? '0 : fetch_pc;
  assign issue    = mem_req && mem_gnt;

  assign drop = mem_rvalid && (discard != '0);
  assign resp = mem_rvalid && (discard == '0);
  assign push = resp && !redirect;

  assign inst_valid = !rst && (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect;
  assign inst       = rst ? '0 : q[rd_ptr].inst;
  assign inst_pc    = rst ? '0 : q[rd_ptr].pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect) begin
      // Everything in flight, including a grant this cycle, becomes stale.
      fetch_pc    <= redir_pc;
      resp_pc     <= redir_pc;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      discard     <= discard + outstanding + CW'(issue) - CW'(mem_rvalid);
      outstanding <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (push) begin
        resp_pc <= resp_pc + 32'd4;
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count       <= count + CW'(push) - CW'(pop);
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      discard     <= discard - CW'(drop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) q[wr_ptr] <= '{inst: mem_rdata, pc: resp_pc};
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue: in-order memory model with random latency,
// epoch-tagged request tracking as reference, plus directed literal checks.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XOR_PAT  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;

  inst_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } pend_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

  pend_t       pend[$];       // requests granted, not yet answered by memory
  ent_t        expq[$];       // words the consumer should see, in order
  logic [31:0] m_fetch_pc = RESET_PC;
  int          epoch = 0, cyc = 0, since_rst = 0, first_valid = -1;
  logic [31:0] grant_log[$], pop_pcs[$], pop_insts[$];
  int          tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit r, input int gnt_pct, input int lat_max,
                       input bit rdy, input bit rd, input logic [31:0] rpc);
    int    outst, due;
    bit    exp_req, issue;
    pend_t h;
    @(negedge clk);
    rst         = r;
    mem_gnt     = ($urandom_range(99) < gnt_pct);
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    mem_rvalid  = !r && pend.size() > 0 && pend[0].due <= cyc;
    mem_rdata   = mem_rvalid ? (pend[0].addr ^ XOR_PAT) : $urandom;
    #1;
    outst = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) outst++;
    exp_req = !r && (expq.size() + outst < DEPTH) && (pend.size() < DEPTH);
    chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
    if (r) begin
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
    end else begin
      chk("mem_addr", mem_addr, m_fetch_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, expq.size() != 0});
      if (expq.size() != 0) begin
        chk("inst", inst, expq[0].inst);
        chk("inst_pc", inst_pc, expq[0].pc);
      end
    end
    // Logs hold what the DUT actually showed, for the directed literal checks.
    if (!r && mem_req && mem_gnt) grant_log.push_back(mem_addr);
    if (!r && inst_valid && rdy && !rd) begin
      pop_pcs.push_back(inst_pc);
      pop_insts.push_back(inst);
    end
    if (!r && inst_valid && first_valid < 0) first_valid = since_rst;

    if (r) begin
      pend.delete();
      expq.delete();
      m_fetch_pc  = RESET_PC;
      since_rst   = 0;
      first_valid = -1;
    end else begin
      issue = exp_req && mem_gnt;
      if (rdy && !rd && expq.size() > 0) void'(expq.pop_front());
      if (mem_rvalid) begin
        h = pend.pop_front();
        if (h.epoch == epoch && !rd) expq.push_back('{inst: mem_rdata, pc: h.addr});
      end
      if (issue) begin
        due = cyc + $urandom_range(lat_max, 1);
        if (pend.size() > 0 && pend[pend.size()-1].due >= due) due = pend[pend.size()-1].due + 1;
        pend.push_back('{addr: m_fetch_pc, epoch: epoch, due: due});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (rd) begin
        epoch++;
        expq.delete();
        m_fetch_pc = {rpc[31:2], 2'b00};
      end
      since_rst++;
    end
    cyc++;
  endtask

  task automatic run(input int n, input int gp, input int lm, input bit rdy);
    repeat (n) cycle(1'b0, gp, lm, rdy, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 100, 1, 1'b0, 1'b0, 32'd0);
    grant_log.delete(); pop_pcs.delete(); pop_insts.delete();
  endtask

  initial begin
    // Zero-wait memory, consumer always ready.
    do_reset(); do_reset();
    run(12, 100, 1, 1'b1);
    chk("first_valid_cycle", 32'(first_valid), 32'd2);
    chk("zw_pc0", at(pop_pcs, 0), 32'h0);
    chk("zw_pc1", at(pop_pcs, 1), 32'h4);
    chk("zw_pc2", at(pop_pcs, 2), 32'h8);
    chk("zw_inst0", at(pop_insts, 0), 32'hA5A5_0000);
    chk("zw_inst2", at(pop_insts, 2), 32'hA5A5_0008);

    // Stalled consumer: exactly DEPTH fetches, then drain and resume.
    do_reset();
    run(20, 100, 1, 1'b0);
    chk("idle_grants", 32'(grant_log.size()), 32'd4);
    chk("idle_g3", at(grant_log, 3), 32'hC);
    run(10, 100, 1, 1'b1);
    chk("drain_pc0", at(pop_pcs, 0), 32'h0);
    chk("drain_pc3", at(pop_pcs, 3), 32'hC);
    chk("resume_addr", at(grant_log, 4), 32'h10);

    // Latency 3 with requests in flight, then redirect.
    do_reset();
    run(2, 100, 3, 1'b0);
    cycle(1'b0, 100, 3, 1'b1, 1'b1, 32'h200);
    run(15, 100, 3, 1'b1);
    chk("redir_pc0", at(pop_pcs, 0), 32'h200);
    chk("redir_inst0", at(pop_insts, 0), 32'hA5A5_0200);
    chk("redir_pc1", at(pop_pcs, 1), 32'h204);

    // Redirect coinciding with rvalid, grant and pop.
    do_reset();
    run(6, 100, 1, 1'b1);
    pop_pcs.delete();
    cycle(1'b0, 100, 1, 1'b1, 1'b1, 32'h400);
    run(8, 100, 1, 1'b1);
    chk("coinc_pc0", at(pop_pcs, 0), 32'h400);

    // Address wrap and low-bit masking of the redirect target.
    cycle(1'b0, 100, 1, 1'b1, 1'b1, 32'hFFFF_FFFB);
    grant_log.delete();
    run(8, 100, 1, 1'b1);
    chk("wrap_g0", at(grant_log, 0), 32'hFFFF_FFF8);
    chk("wrap_g1", at(grant_log, 1), 32'hFFFF_FFFC);
    chk("wrap_g2", at(grant_log, 2), 32'h0000_0000);
    chk("wrap_g3", at(grant_log, 3), 32'h0000_0004);
    cycle(1'b0, 100, 1, 1'b1, 1'b1, 32'h103);
    grant_log.delete();
    run(3, 100, 1, 1'b1);
    chk("mask_g0", at(grant_log, 0), 32'h100);

    // Reset while busy.
    do_reset();
    run(3, 100, 2, 1'b0);
    do_reset();
    run(3, 100, 1, 1'b0);
    chk("rst_restart", at(grant_log, 0), RESET_PC);

    // Random traffic with occasional redirects and resets.
    do_reset();
    for (int b = 0; b < 20; b++) begin
      int gp, lm, rp;
      gp = $urandom_range(100, 20);
      lm = $urandom_range(5, 1);
      rp = $urandom_range(100, 10);
      for (int i = 0; i < 150; i++) begin
        bit rr, rd;
        rr = ($urandom_range(199) == 0);
        rd = ($urandom_range(99) < 4);
        cycle(rr, gp, lm, ($urandom_range(99) < rp), rd, $urandom_range(4095, 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
